// File: rtl/note_if.sv
// Note handshake between the song sequencer (master) and the note player (slave).
interface note_if;
  logic       new_note;
  logic [5:0] note;
  logic [5:0] duration;
  logic       note_done;

  modport master (output new_note, output note, output duration, input note_done);
  modport slave  (input new_note, input note, input duration, output note_done);
endinterface

// File: rtl/note_player.sv
// Latches a note on new_note, plays it as a square wave for dur_q beats, then pulses note_done.
// Registered state; new_note wins over any beat in the same cycle; pause freezes beats and tone phase.
module note_player #(
  parameter int HALF_BITS = 20,
  parameter int SIM_SHIFT = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic play,
  input  logic beat,
  note_if.slave seq,
  output logic tone,
  output logic busy
);

  typedef enum logic [1:0] {IDLE, PLAYING, DONE} state_t;

  state_t                state_q, state_d;
  logic [5:0]            note_q, note_d;
  logic [5:0]            dur_q, dur_d;
  logic [5:0]            beat_cnt_q, beat_cnt_d;
  logic [HALF_BITS-1:0]  half_cnt_q, half_cnt_d;
  logic                  tone_q, tone_d;

  logic [5:0]            idx;
  logic [2:0]            oct;
  logic [5:0]            semi;
  logic [14:0]           base;
  logic [19:0]           half_full;
  logic [HALF_BITS-1:0]  half;
  logic                  running;

  // Octave/semitone split by range compare instead of a divider; note_q = 0 never runs.
  always_comb begin
    idx = note_q - 6'd1;
    if      (idx >= 6'd60) oct = 3'd5;
    else if (idx >= 6'd48) oct = 3'd4;
    else if (idx >= 6'd36) oct = 3'd3;
    else if (idx >= 6'd24) oct = 3'd2;
    else if (idx >= 6'd12) oct = 3'd1;
    else                   oct = 3'd0;
    semi = idx - ({oct, 3'b000} + {1'b0, oct, 2'b00});
    case (semi)
      6'd0:    base = 15'd23889;
      6'd1:    base = 15'd22548;
      6'd2:    base = 15'd21283;
      6'd3:    base = 15'd20088;
      6'd4:    base = 15'd18961;
      6'd5:    base = 15'd17897;
      6'd6:    base = 15'd16892;
      6'd7:    base = 15'd15944;
      6'd8:    base = 15'd15051;
      6'd9:    base = 15'd14205;
      6'd10:   base = 15'd13408;
      default: base = 15'd12655;
    endcase
    half_full = {5'b0, base} << (3'd5 - oct);
    half      = HALF_BITS'(half_full >> SIM_SHIFT);
  end

  assign running       = (state_q == PLAYING) && play && (note_q != 6'd0);
  assign busy          = (state_q == PLAYING);
  assign seq.note_done = (state_q == DONE);
  assign tone          = tone_q & running;

  always_comb begin
    state_d    = state_q;
    note_d     = note_q;
    dur_d      = dur_q;
    beat_cnt_d = beat_cnt_q;
    half_cnt_d = half_cnt_q;
    tone_d     = tone_q;

    if (running) begin
      if (half_cnt_q == half - HALF_BITS'(1)) begin
        half_cnt_d = '0;
        tone_d     = ~tone_q;
      end else begin
        half_cnt_d = half_cnt_q + HALF_BITS'(1);
      end
    end

    case (state_q)
      PLAYING: begin
        if (beat && play) begin
          if (beat_cnt_q + 6'd1 == dur_q) state_d    = DONE;
          else                            beat_cnt_d = beat_cnt_q + 6'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = state_q;
    endcase

    // A fresh strobe aborts whatever is in flight, including a coincident final beat.
    if (seq.new_note) begin
      note_d     = seq.note;
      dur_d      = seq.duration;
      beat_cnt_d = '0;
      half_cnt_d = '0;
      tone_d     = 1'b0;
      state_d    = (seq.duration != 6'd0) ? PLAYING : DONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      note_q     <= '0;
      dur_q      <= '0;
      beat_cnt_q <= '0;
      half_cnt_q <= '0;
      tone_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      note_q     <= note_d;
      dur_q      <= dur_d;
      beat_cnt_q <= beat_cnt_d;
      half_cnt_q <= half_cnt_d;
      tone_q     <= tone_d;
    end
  end

endmodule

// File: tb/tb_note_player.sv
// Directed-plus-random bench for note_player against a beats-remaining / elapsed-time reference model.
module tb_note_player;

  localparam int SH = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic play = 1'b0;
  logic beat = 1'b0;
  logic tone, busy;

  note_if sif ();

  note_player #(.HALF_BITS(20), .SIM_SHIFT(SH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .play    (play),
    .beat    (beat),
    .seq     (sif.slave),
    .tone    (tone),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int tbl[12] = '{23889, 22548, 21283, 20088, 18961, 17897,
                  16892, 15944, 15051, 14205, 13408, 12655};

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: 0 = idle, 1 = playing, 2 = done
  int m_mode    = 0;
  int m_note    = 0;
  int m_left    = 0;
  int m_elapsed = 0;

  function automatic int half_of(input int n);
    int s, o;
    s = (n - 1) % 12;
    o = (n - 1) / 12;
    return (tbl[s] << (5 - o)) >> SH;
  endfunction

  function automatic logic exp_tone();
    if (m_mode == 1 && play && m_note != 0)
      return logic'((m_elapsed / half_of(m_note)) % 2);
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_mode = 0; m_note = 0; m_left = 0; m_elapsed = 0;
  endtask

  task automatic model_step(input logic b, input logic p, input logic nn,
                            input logic [5:0] n, input logic [5:0] d);
    logic run;
    run = (m_mode == 1) && p && (m_note != 0);
    if (nn) begin
      m_note = int'(n); m_left = int'(d); m_elapsed = 0;
      m_mode = (d != 0) ? 1 : 2;
    end else if (m_mode == 1) begin
      if (run) m_elapsed++;
      if (b && p) begin
        m_left--;
        if (m_left == 0) m_mode = 2;
      end
    end else if (m_mode == 2) begin
      m_mode = 0;
    end
  endtask

  // One clock: drive at negedge, check just after, advance model at posedge.
  task automatic cyc(input logic b, input logic p, input logic nn,
                     input logic [5:0] n, input logic [5:0] d);
    @(negedge clk);
    beat = b; play = p; sif.new_note = nn;
    sif.note     = nn ? n : 6'($urandom);
    sif.duration = nn ? d : 6'($urandom);
    #1;
    chk("busy", 32'(busy), 32'(m_mode == 1));
    chk("note_done", 32'(sif.note_done), 32'(m_mode == 2));
    chk("tone", 32'(tone), 32'(exp_tone()));
    @(posedge clk);
    if (reset_n) model_step(b, p, nn, n, d);
  endtask

  task automatic run_beats(input int period, input int pause_pct, input int cap);
    logic p;
    for (int c = 1; c <= cap && m_mode != 0; c++) begin
      p = ($urandom_range(99) >= pause_pct);
      cyc((c % period) == 0, p, 1'b0, 6'd0, 6'd0);
    end
  endtask

  task automatic run_note(input int n, input int d, input int period,
                          input int pause_pct, input int cap);
    cyc(1'b0, 1'b1, 1'b1, 6'(n), 6'(d));
    run_beats(period, pause_pct, cap);
  endtask

  initial begin
    sif.new_note = 1'b0; sif.note = '0; sif.duration = '0;
    model_reset();

    // Reset state
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 6'd0, 6'd0);
    @(negedge clk); reset_n = 1'b1;

    // Basic note, then tone periods at several octaves
    run_note(61, 3, 100, 0, 400);
    run_note(61, 4, 300, 0, 1500);
    run_note(1, 2, 3000, 0, 6500);
    run_note(22, 3, 400, 0, 1500);

    // Pause after the first of three beats for five beats
    cyc(1'b0, 1'b1, 1'b1, 6'd30, 6'd3);
    for (int c = 1; c <= 600 && m_mode != 0; c++)
      cyc((c % 50) == 0, !(c > 50 && c <= 300), 1'b0, 6'd0, 6'd0);

    // End-of-song marker and rest
    run_note(40, 0, 10, 0, 20);
    run_note(0, 2, 20, 0, 100);

    // Strobe coincident with the final beat
    cyc(1'b0, 1'b1, 1'b1, 6'd50, 6'd2);
    for (int c = 1; c < 20; c++) cyc((c % 10) == 0, 1'b1, 1'b0, 6'd0, 6'd0);
    cyc(1'b1, 1'b1, 1'b1, 6'd45, 6'd3);
    run_beats(10, 0, 100);

    // Strobe while in DONE
    cyc(1'b0, 1'b1, 1'b1, 6'd12, 6'd1);
    for (int c = 1; c <= 20 && m_mode != 2; c++) cyc((c % 5) == 0, 1'b1, 1'b0, 6'd0, 6'd0);
    chk("reached_done", 32'(m_mode), 32'd2);
    cyc(1'b0, 1'b1, 1'b1, 6'd13, 6'd2);
    run_beats(7, 0, 100);

    // Asynchronous reset mid-note
    cyc(1'b0, 1'b1, 1'b1, 6'd63, 6'd5);
    run_beats(40, 0, 120);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tone", 32'(tone), 32'd0);
    chk("rst_done", 32'(sif.note_done), 32'd0);
    @(negedge clk); #2; reset_n = 1'b1;
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, 1'b0, 6'd0, 6'd0);

    // Random notes, some cut short by the next strobe
    for (int i = 0; i < 30; i++)
      run_note($urandom_range(63), $urandom_range(6), $urandom_range(25, 4),
               $urandom_range(15), ($urandom_range(3) == 0) ? $urandom_range(40, 1) : 250);
    run_beats(8, 0, 200);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
